// File: rtl/ps2_cmd_scheduler.sv
// ps2_cmd_scheduler: runtime PS/2 mouse command controller.
// Borrows the shared PS/2 transmitter/receiver from the streaming master at a
// packet boundary. Sends a one- or two-byte host command and collects the ACK,
// with resend and timeout handling. Then hands the bus back.
// Optional feature macro: PS2_RESP_CAPTURE_EN adds CMD_HAS_RESP / RESP_DATA so
// one response byte after the final ACK can be captured (e.g. F2 Get ID).
module ps2_cmd_scheduler #(
  parameter logic [23:0] ACK_TIMEOUT = 24'd1000000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_REQ,
  input  logic [7:0] CMD_CODE,
  input  logic [7:0] CMD_ARG,
  input  logic       CMD_HAS_ARG,
`ifdef PS2_RESP_CAPTURE_EN
  input  logic       CMD_HAS_RESP,
  output logic [7:0] RESP_DATA,
`endif
  output logic       CMD_BUSY,
  output logic       CMD_DONE,
  output logic [1:0] CMD_STATUS,
  input  logic       PACKET_BOUNDARY,
  output logic       STREAM_HOLD,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY
);

  typedef enum logic [3:0] {
    ST_IDLE          = 4'd0,
    ST_WAIT_BOUNDARY = 4'd1,
    ST_SEND_CMD      = 4'd2,
    ST_SEND_ARG      = 4'd3,
    ST_WAIT_CMD_ACK  = 4'd4,
    ST_WAIT_ARG_ACK  = 4'd5,
    ST_WAIT_RESP     = 4'd6,
    ST_DONE          = 4'd7
  } state_t;

  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [7:0] BYTE_ERROR  = 8'hFC;

  state_t      state_q, state_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  arg_q, arg_d;
  logic        has_arg_q, has_arg_d;
  logic [3:0]  retry_q, retry_d;
  logic [23:0] tmo_q, tmo_d;
  logic [1:0]  status_q, status_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        hold_q, hold_d;
  logic        send_q, send_d;
  logic        read_q, read_d;
  logic [7:0]  byte_q, byte_d;
`ifdef PS2_RESP_CAPTURE_EN
  logic        has_resp_q, has_resp_d;
  logic [7:0]  resp_q, resp_d;
`endif

  logic   retry_ok_s;
  logic   timeout_s;
  logic   rx_bad_s;
  state_t resend_st_s;
  state_t final_st_s;

  // Helper decodes: resend budget, timeout, bad receive, resend/final targets.
  always_comb begin
    retry_ok_s = (retry_q < MAX_RETRY[3:0]);
    timeout_s  = (tmo_q >= (ACK_TIMEOUT - 24'd1));
    rx_bad_s   = (BYTE_ERROR_CODE != 2'b00) || (BYTE_READ == BYTE_RESEND);
    // A resend from the response wait repeats the last byte put on the wire.
    if (state_q == ST_WAIT_ARG_ACK) begin
      resend_st_s = ST_SEND_ARG;
    end else if ((state_q == ST_WAIT_RESP) && has_arg_q) begin
      resend_st_s = ST_SEND_ARG;
    end else begin
      resend_st_s = ST_SEND_CMD;
    end
`ifdef PS2_RESP_CAPTURE_EN
    if (has_resp_q) begin
      final_st_s = ST_WAIT_RESP;
    end else begin
      final_st_s = ST_DONE;
    end
`else
    final_st_s = ST_DONE;
`endif
  end

  // Next-state logic for the command handshake and its bookkeeping registers.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    arg_d     = arg_q;
    has_arg_d = has_arg_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    status_d  = status_q;
`ifdef PS2_RESP_CAPTURE_EN
    has_resp_d = has_resp_q;
    resp_d     = resp_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (CMD_REQ) begin
          code_d    = CMD_CODE;
          arg_d     = CMD_ARG;
          has_arg_d = CMD_HAS_ARG;
`ifdef PS2_RESP_CAPTURE_EN
          has_resp_d = CMD_HAS_RESP;
`endif
          retry_d   = 4'd0;
          tmo_d     = 24'd0;
          state_d   = ST_WAIT_BOUNDARY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_BOUNDARY: begin
        if (PACKET_BOUNDARY) begin
          state_d = ST_SEND_CMD;
        end else begin
          state_d = ST_WAIT_BOUNDARY;
        end
      end
      ST_SEND_CMD, ST_SEND_ARG: begin
        tmo_d = 24'd0;
        if (BYTE_SENT) begin
          state_d = (state_q == ST_SEND_CMD) ? ST_WAIT_CMD_ACK : ST_WAIT_ARG_ACK;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT_CMD_ACK, ST_WAIT_ARG_ACK, ST_WAIT_RESP: begin
        // Saturating counter; discarded stream bytes do not restart it.
        if (tmo_q != 24'hFFFFFF) begin
          tmo_d = tmo_q + 24'd1;
        end else begin
          tmo_d = tmo_q;
        end
        // A received byte takes priority over a coincident timeout.
        if (BYTE_READY) begin
          if (rx_bad_s) begin
            if (retry_ok_s) begin
              retry_d = retry_q + 4'd1;
              state_d = resend_st_s;
            end else begin
              status_d = 2'b01;
              state_d  = ST_DONE;
            end
          end else if (state_q == ST_WAIT_RESP) begin
`ifdef PS2_RESP_CAPTURE_EN
            resp_d = BYTE_READ;
`endif
            status_d = 2'b00;
            state_d  = ST_DONE;
          end else if (BYTE_READ == BYTE_ERROR) begin
            status_d = 2'b10;
            state_d  = ST_DONE;
          end else if (BYTE_READ == BYTE_ACK) begin
            status_d = 2'b00;
            if ((state_q == ST_WAIT_CMD_ACK) && has_arg_q) begin
              state_d = ST_SEND_ARG;
            end else begin
              state_d = final_st_s;
            end
          end else begin
            state_d = state_q;
          end
        end else if (timeout_s) begin
          if (retry_ok_s) begin
            retry_d = retry_q + 4'd1;
            state_d = resend_st_s;
          end else begin
            status_d = 2'b11;
            state_d  = ST_DONE;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the upcoming state, so every output leaves a flop.
  always_comb begin
    busy_d = 1'b1;
    hold_d = 1'b0;
    send_d = 1'b0;
    read_d = 1'b0;
    done_d = 1'b0;
    byte_d = 8'h00;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_WAIT_BOUNDARY: begin
        hold_d = 1'b0;
      end
      ST_SEND_CMD: begin
        hold_d = 1'b1;
        send_d = 1'b1;
        byte_d = code_q;
      end
      ST_SEND_ARG: begin
        hold_d = 1'b1;
        send_d = 1'b1;
        byte_d = arg_q;
      end
      ST_WAIT_CMD_ACK, ST_WAIT_ARG_ACK, ST_WAIT_RESP: begin
        hold_d = 1'b1;
        read_d = 1'b1;
      end
      ST_DONE: begin
        hold_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, latched command fields, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      code_q    <= 8'h00;
      arg_q     <= 8'h00;
      has_arg_q <= 1'b0;
      retry_q   <= 4'd0;
      tmo_q     <= 24'd0;
      status_q  <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hold_q    <= 1'b0;
      send_q    <= 1'b0;
      read_q    <= 1'b0;
      byte_q    <= 8'h00;
`ifdef PS2_RESP_CAPTURE_EN
      has_resp_q <= 1'b0;
      resp_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      arg_q     <= arg_d;
      has_arg_q <= has_arg_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      status_q  <= status_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hold_q    <= hold_d;
      send_q    <= send_d;
      read_q    <= read_d;
      byte_q    <= byte_d;
`ifdef PS2_RESP_CAPTURE_EN
      has_resp_q <= has_resp_d;
      resp_q     <= resp_d;
`endif
    end
  end

  assign CMD_BUSY     = busy_q;
  assign CMD_DONE     = done_q;
  assign CMD_STATUS   = status_q;
  assign STREAM_HOLD  = hold_q;
  assign SEND_BYTE    = send_q;
  assign BYTE_TO_SEND = byte_q;
  assign READ_ENABLE  = read_q;
`ifdef PS2_RESP_CAPTURE_EN
  assign RESP_DATA    = resp_q;
`endif

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Directed testbench for ps2_cmd_scheduler (ACK_TIMEOUT = 100, MAX_RETRY = 2).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_ps2_cmd_scheduler;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CMD_REQ;
  logic [7:0] CMD_CODE;
  logic [7:0] CMD_ARG;
  logic       CMD_HAS_ARG;
`ifdef PS2_RESP_CAPTURE_EN
  logic       CMD_HAS_RESP;
  logic [7:0] RESP_DATA;
`endif
  logic       CMD_BUSY;
  logic       CMD_DONE;
  logic [1:0] CMD_STATUS;
  logic       PACKET_BOUNDARY;
  logic       STREAM_HOLD;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  ps2_cmd_scheduler #(
    .ACK_TIMEOUT(24'd100),
    .MAX_RETRY  (2)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .CMD_REQ        (CMD_REQ),
    .CMD_CODE       (CMD_CODE),
    .CMD_ARG        (CMD_ARG),
    .CMD_HAS_ARG    (CMD_HAS_ARG),
`ifdef PS2_RESP_CAPTURE_EN
    .CMD_HAS_RESP   (CMD_HAS_RESP),
    .RESP_DATA      (RESP_DATA),
`endif
    .CMD_BUSY       (CMD_BUSY),
    .CMD_DONE       (CMD_DONE),
    .CMD_STATUS     (CMD_STATUS),
    .PACKET_BOUNDARY(PACKET_BOUNDARY),
    .STREAM_HOLD    (STREAM_HOLD),
    .SEND_BYTE      (SEND_BYTE),
    .BYTE_TO_SEND   (BYTE_TO_SEND),
    .BYTE_SENT      (BYTE_SENT),
    .READ_ENABLE    (READ_ENABLE),
    .BYTE_READ      (BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BYTE_READY     (BYTE_READY)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic start_cmd(input logic [7:0] code, input logic [7:0] arg,
                           input logic has_arg, input logic has_resp);
    CMD_CODE    = code;
    CMD_ARG     = arg;
    CMD_HAS_ARG = has_arg;
`ifdef PS2_RESP_CAPTURE_EN
    CMD_HAS_RESP = has_resp;
`else
    if (has_resp) $display("note: response capture not built in");
`endif
    CMD_REQ = 1'b1;
    cyc(1);
  endtask

  // Waits (bounded) for a transmit request and acknowledges it with BYTE_SENT.
  task automatic wait_send(output int cnt, output logic [7:0] b);
    cnt = 0;
    while (SEND_BYTE !== 1'b1 && cnt < 500) begin
      cyc(1);
      cnt++;
    end
    b = BYTE_TO_SEND;
    if (SEND_BYTE === 1'b1) begin
      BYTE_SENT = 1'b1;
      cyc(1);
      BYTE_SENT = 1'b0;
    end
  endtask

  task automatic respond(input logic [7:0] b, input logic [1:0] err);
    BYTE_READ       = b;
    BYTE_ERROR_CODE = err;
    BYTE_READY      = 1'b1;
    cyc(1);
    BYTE_READY      = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  // Waits (bounded) for CMD_DONE, captures status and releases the request.
  task automatic wait_done(output logic seen, output logic [1:0] st, output int cnt);
    cnt = 0;
    while (CMD_DONE !== 1'b1 && cnt < 1000) begin
      cyc(1);
      cnt++;
    end
    seen    = (CMD_DONE === 1'b1);
    st      = CMD_STATUS;
    CMD_REQ = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    cyc(3);
    checks++;
    if ({CMD_BUSY, CMD_DONE, CMD_STATUS, STREAM_HOLD, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE}
        !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want all zero",
               {CMD_BUSY, CMD_DONE, CMD_STATUS, STREAM_HOLD, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE});
    end
    RESET = 1'b0;
    cyc(1);
  endtask

  task automatic test_set_rate;
    int cnt;
    logic [7:0] b;
    logic seen;
    logic [1:0] st;
    start_cmd(8'hF3, 8'h64, 1'b1, 1'b0);
    checks++;
    if ({CMD_BUSY, STREAM_HOLD} !== 2'b10) begin
      errors++;
      $display("FAIL accept_busy: got busy/hold %b want 10", {CMD_BUSY, STREAM_HOLD});
    end
    CMD_CODE = 8'h00;
    CMD_ARG  = 8'h00;
    wait_send(cnt, b);
    checks++;
    if (b !== 8'hF3) begin
      errors++;
      $display("FAIL rate_cmd_byte: got %h want f3 (after %0d cycles)", b, cnt);
    end
    checks++;
    if ({READ_ENABLE, STREAM_HOLD, SEND_BYTE} !== 3'b110) begin
      errors++;
      $display("FAIL rate_wait_ack: got rd/hold/send %b want 110", {READ_ENABLE, STREAM_HOLD, SEND_BYTE});
    end
    respond(8'hFA, 2'b00);
    wait_send(cnt, b);
    checks++;
    if (b !== 8'h64) begin
      errors++;
      $display("FAIL rate_arg_byte: got %h want 64", b);
    end
    respond(8'hFA, 2'b00);
    wait_done(seen, st, cnt);
    checks++;
    if ({seen, st, cnt == 0} !== 4'b1001) begin
      errors++;
      $display("FAIL rate_done: got seen=%b status=%b wait=%0d want 1 00 0", seen, st, cnt);
    end
    checks++;
    if ({CMD_BUSY, STREAM_HOLD, READ_ENABLE} !== 3'b110) begin
      errors++;
      $display("FAIL rate_done_cycle: got busy/hold/rd %b want 110", {CMD_BUSY, STREAM_HOLD, READ_ENABLE});
    end
    cyc(1);
    checks++;
    if ({CMD_BUSY, STREAM_HOLD, CMD_DONE, CMD_STATUS} !== 5'b00000) begin
      errors++;
      $display("FAIL rate_after_done: got %b want 00000", {CMD_BUSY, STREAM_HOLD, CMD_DONE, CMD_STATUS});
    end
  endtask

  task automatic test_boundary_wait;
    int cnt;
    logic [7:0] b;
    logic seen;
    logic [1:0] st;
    logic bad;
    PACKET_BOUNDARY = 1'b0;
    start_cmd(8'hF4, 8'h00, 1'b0, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (SEND_BYTE !== 1'b0 || STREAM_HOLD !== 1'b0 || CMD_BUSY !== 1'b1) bad = 1'b1;
      cyc(1);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL boundary_hold_off: got bus activity before boundary, want none");
    end
    PACKET_BOUNDARY = 1'b1;
    wait_send(cnt, b);
    checks++;
    if (b !== 8'hF4 || cnt < 1 || cnt > 2) begin
      errors++;
      $display("FAIL boundary_send: got byte %h after %0d cycles want f4 within 2", b, cnt);
    end
    respond(8'hFA, 2'b00);
    wait_done(seen, st, cnt);
    checks++;
    if ({seen, st} !== 3'b100) begin
      errors++;
      $display("FAIL boundary_done: got seen=%b status=%b want 1 00", seen, st);
    end
    cyc(1);
  endtask

  task automatic test_resend_arg;
    int cnt;
    logic [7:0] b;
    logic seen;
    logic [1:0] st;
    start_cmd(8'hE8, 8'h03, 1'b1, 1'b0);
    CMD_REQ = 1'b0;
    CMD_ARG = 8'h55;
    wait_send(cnt, b);
    respond(8'hFA, 2'b00);
    wait_send(cnt, b);
    respond(8'hFE, 2'b00);
    wait_send(cnt, b);
    checks++;
    if (b !== 8'h03) begin
      errors++;
      $display("FAIL resend_arg_byte: got %h want 03", b);
    end
    respond(8'hFA, 2'b00);
    wait_done(seen, st, cnt);
    checks++;
    if ({seen, st} !== 3'b100) begin
      errors++;
      $display("FAIL resend_arg_done: got seen=%b status=%b want 1 00", seen, st);
    end
    cyc(1);
  endtask

  task automatic test_retry_exhaust;
    int cnt;
    int sends;
    logic [7:0] b;
    logic seen;
    logic [1:0] st;
    start_cmd(8'hE8, 8'h01, 1'b1, 1'b0);
    sends = 0;
    for (int i = 0; i < 3; i++) begin
      wait_send(cnt, b);
      if (b === 8'hE8) sends++;
      if (i == 1) respond(8'h00, 2'b01);
      else        respond(8'hFE, 2'b00);
    end
    wait_done(seen, st, cnt);
    checks++;
    if ({seen, st, cnt == 0} !== 4'b1011 || sends != 3) begin
      errors++;
      $display("FAIL retry_exhaust: got seen=%b status=%b sends=%0d want 1 01 3", seen, st, sends);
    end
    cyc(1);
  endtask

  task automatic test_timeout;
    int cnt;
    int gap1;
    int sends;
    logic [7:0] b;
    logic seen;
    logic [1:0] st;
    start_cmd(8'hF5, 8'h00, 1'b0, 1'b0);
    sends = 0;
    gap1  = 0;
    for (int i = 0; i < 3; i++) begin
      wait_send(cnt, b);
      if (b === 8'hF5) sends++;
      if (i == 1) gap1 = cnt;
    end
    checks++;
    if (gap1 != 100 || sends != 3) begin
      errors++;
      $display("FAIL timeout_resend: got gap=%0d sends=%0d want 100 3", gap1, sends);
    end
    wait_done(seen, st, cnt);
    checks++;
    if ({seen, st} !== 3'b111 || cnt != 100) begin
      errors++;
      $display("FAIL timeout_status: got seen=%b status=%b wait=%0d want 1 11 100", seen, st, cnt);
    end
    cyc(1);
    // FA in the very cycle the counter expires must win.
    start_cmd(8'hF5, 8'h00, 1'b0, 1'b0);
    wait_send(cnt, b);
    cyc(99);
    respond(8'hFA, 2'b00);
    wait_done(seen, st, cnt);
    checks++;
    if ({seen, st, cnt == 0} !== 4'b1001) begin
      errors++;
      $display("FAIL timeout_vs_ack: got seen=%b status=%b wait=%0d want 1 00 0", seen, st, cnt);
    end
    cyc(1);
  endtask

  task automatic test_discard_fc;
    int cnt;
    logic [7:0] b;
    logic seen;
    logic [1:0] st;
    start_cmd(8'hF4, 8'h00, 1'b0, 1'b0);
    wait_send(cnt, b);
    respond(8'h08, 2'b00);
    checks++;
    if ({READ_ENABLE, CMD_DONE, SEND_BYTE} !== 3'b100) begin
      errors++;
      $display("FAIL discard_stream_byte: got rd/done/send %b want 100", {READ_ENABLE, CMD_DONE, SEND_BYTE});
    end
    respond(8'hFC, 2'b00);
    wait_done(seen, st, cnt);
    checks++;
    if ({seen, st, cnt == 0} !== 4'b1101) begin
      errors++;
      $display("FAIL mouse_error: got seen=%b status=%b want 1 10", seen, st);
    end
    cyc(1);
  endtask

  task automatic test_reset_mid;
    int cnt;
    logic [7:0] b;
    logic seen;
    logic [1:0] st;
    start_cmd(8'hE8, 8'h02, 1'b1, 1'b0);
    wait_send(cnt, b);
    respond(8'hFA, 2'b00);
    checks++;
    if ({SEND_BYTE, BYTE_TO_SEND} !== 9'h102) begin
      errors++;
      $display("FAIL mid_send_arg: got send/byte %b/%h want 1/02", SEND_BYTE, BYTE_TO_SEND);
    end
    RESET   = 1'b1;
    CMD_REQ = 1'b0;
    cyc(1);
    checks++;
    if ({CMD_BUSY, CMD_DONE, CMD_STATUS, STREAM_HOLD, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE}
        !== 15'd0) begin
      errors++;
      $display("FAIL mid_reset: got %b want all zero",
               {CMD_BUSY, CMD_DONE, CMD_STATUS, STREAM_HOLD, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE});
    end
    RESET = 1'b0;
    cyc(1);
    start_cmd(8'hF4, 8'h00, 1'b0, 1'b0);
    wait_send(cnt, b);
    checks++;
    if (b !== 8'hF4) begin
      errors++;
      $display("FAIL post_reset_cmd: got %h want f4", b);
    end
    respond(8'hFA, 2'b00);
    wait_done(seen, st, cnt);
    checks++;
    if ({seen, st} !== 3'b100) begin
      errors++;
      $display("FAIL post_reset_done: got seen=%b status=%b want 1 00", seen, st);
    end
    cyc(1);
  endtask

`ifdef PS2_RESP_CAPTURE_EN
  task automatic test_resp_capture;
    int cnt;
    int sends;
    logic [7:0] b;
    logic seen;
    logic [1:0] st;
    logic [7:0] resp_vals [2];
    resp_vals[0] = 8'h03;
    resp_vals[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      start_cmd(8'hF2, 8'h00, 1'b0, 1'b1);
      wait_send(cnt, b);
      respond(8'hFA, 2'b00);
      checks++;
      if ({READ_ENABLE, CMD_DONE} !== 2'b10) begin
        errors++;
        $display("FAIL resp_wait: got rd/done %b want 10", {READ_ENABLE, CMD_DONE});
      end
      respond(resp_vals[k], 2'b00);
      wait_done(seen, st, cnt);
      checks++;
      if ({seen, st} !== 3'b100 || RESP_DATA !== resp_vals[k]) begin
        errors++;
        $display("FAIL resp_data: got seen=%b status=%b data=%h want 1 00 %h", seen, st, RESP_DATA, resp_vals[k]);
      end
      cyc(1);
    end
    start_cmd(8'hF2, 8'h00, 1'b0, 1'b1);
    sends = 0;
    for (int i = 0; i < 3; i++) begin
      wait_send(cnt, b);
      if (b === 8'hF2) sends++;
      respond(8'hFA, 2'b00);
    end
    wait_done(seen, st, cnt);
    checks++;
    if ({seen, st} !== 3'b111 || sends != 3) begin
      errors++;
      $display("FAIL resp_timeout: got seen=%b status=%b sends=%0d want 1 11 3", seen, st, sends);
    end
    cyc(1);
  endtask
`endif

  initial begin
    RESET           = 1'b1;
    CMD_REQ         = 1'b0;
    CMD_CODE        = 8'h00;
    CMD_ARG         = 8'h00;
    CMD_HAS_ARG     = 1'b0;
`ifdef PS2_RESP_CAPTURE_EN
    CMD_HAS_RESP    = 1'b0;
`endif
    PACKET_BOUNDARY = 1'b1;
    BYTE_SENT       = 1'b0;
    BYTE_READ       = 8'h00;
    BYTE_ERROR_CODE = 2'b00;
    BYTE_READY      = 1'b0;
    test_reset();
    test_set_rate();
    test_boundary_wait();
    test_resend_arg();
    test_retry_exhaust();
    test_timeout();
    test_discard_fc();
    test_reset_mid();
`ifdef PS2_RESP_CAPTURE_EN
    test_resp_capture();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
